param_measure_sequencer: RTL and testbench

PARAM_MEASURE_SEQUENCER -- requirements
Module: param_measure_sequencer

---
 rtl/param_measure_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_param_measure_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/param_measure_sequencer.sv
// Measurement sequencer: clear, gate, settle, shared restoring divide, publish over valid/ready.
// Define PSEQ_THD_EN to add the harmonic/fundamental (THD) divide; otherwise thd_out stays 0.
module param_measure_sequencer #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SCALE      = 1000,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             continuous,
  input  logic             abort,
  input  logic [19:0]      gate_len,
  input  logic             sample_valid,
  input  logic [CNT_W-1:0] zc_cnt,
  input  logic [CNT_W-1:0] high_cnt,
  input  logic [CNT_W-1:0] total_cnt,
  input  logic [CNT_W-1:0] fund_pow,
  input  logic [CNT_W-1:0] harm_pow,
  output logic             win_clr,
  output logic             meas_en,
  output logic [15:0]      freq_out,
  output logic [15:0]      duty_out,
  output logic [15:0]      thd_out,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy,
  output logic             err_div0
);

  localparam int unsigned NUM_W       = CNT_W + 10;
  localparam int unsigned GL_W        = 20;
  localparam int unsigned OUT_W       = 16;
  localparam int unsigned IT_W        = $clog2(NUM_W + 1);
  localparam int unsigned SETTLE_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam int unsigned ST_W        = $clog2(SETTLE_LAST + 2);

  typedef enum logic [2:0] {
    IDLE, CLEAR, GATE, SETTLE, DIV_DUTY, DIV_THD, PUBLISH
  } state_t;

  state_t            state;
  logic [GL_W-1:0]   gate_len_q;
  logic [GL_W-1:0]   gate_cnt;
  logic [ST_W-1:0]   settle_cnt;
  logic [OUT_W-1:0]  zc_s;
  logic [CNT_W-1:0]  high_s;
  logic [CNT_W-1:0]  total_s;
`ifdef PSEQ_THD_EN
  logic [CNT_W-1:0]  fund_s;
  logic [CNT_W-1:0]  harm_s;
  logic [OUT_W-1:0]  duty_q;
`endif

  // Shared divider: dvd shifts the numerator out and the quotient in.
  logic [NUM_W-1:0]  dvd;
  logic [CNT_W-1:0]  dsr;
  logic [CNT_W-1:0]  rem;
  logic [IT_W-1:0]   it_cnt;
  logic              div_busy;

  logic [CNT_W-1:0]  num_sel;
  logic [CNT_W-1:0]  dsr_sel;
  logic [CNT_W:0]    rem_shift;
  logic [CNT_W:0]    rem_diff;
  logic              rem_ge;
  logic [CNT_W-1:0]  rem_next;
  logic [NUM_W-1:0]  dvd_next;
  logic [OUT_W-1:0]  quot_sat;
  logic [OUT_W-1:0]  div_res;
  logic              div_zero;
  logic              div_last;
  logic              div_fin;

  always_comb begin
    num_sel = high_s;
    dsr_sel = total_s;
`ifdef PSEQ_THD_EN
    if (state == DIV_THD) begin
      num_sel = harm_s;
      dsr_sel = fund_s;
    end
`endif
    rem_shift = {rem, dvd[NUM_W-1]};
    rem_diff  = rem_shift - {1'b0, dsr};
    rem_ge    = (rem_shift >= {1'b0, dsr});
    rem_next  = rem_ge ? rem_diff[CNT_W-1:0] : rem_shift[CNT_W-1:0];
    dvd_next  = {dvd[NUM_W-2:0], rem_ge};
    quot_sat  = (|dvd_next[NUM_W-1:OUT_W]) ? {OUT_W{1'b1}} : dvd_next[OUT_W-1:0];
    div_zero  = !div_busy && (dsr_sel == '0);
    div_last  = div_busy && (it_cnt == IT_W'(1));
    div_res   = div_zero ? '0 : quot_sat;
    div_fin   = ((state == DIV_DUTY) || (state == DIV_THD)) && (div_zero || div_last);
  end

  logic unused_bits;
`ifdef PSEQ_THD_EN
  assign unused_bits = ^{zc_cnt[CNT_W-1:OUT_W], rem_diff[CNT_W]};
`else
  assign unused_bits = ^{zc_cnt[CNT_W-1:OUT_W], rem_diff[CNT_W], fund_pow, harm_pow};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gate_len_q   <= '0;
      gate_cnt     <= '0;
      settle_cnt   <= '0;
      zc_s         <= '0;
      high_s       <= '0;
      total_s      <= '0;
`ifdef PSEQ_THD_EN
      fund_s       <= '0;
      harm_s       <= '0;
      duty_q       <= '0;
`endif
      dvd          <= '0;
      dsr          <= '0;
      rem          <= '0;
      it_cnt       <= '0;
      div_busy     <= 1'b0;
      win_clr      <= 1'b0;
      meas_en      <= 1'b0;
      freq_out     <= '0;
      duty_out     <= '0;
      thd_out      <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      err_div0     <= 1'b0;
    end else if (abort) begin
      // Published outputs are deliberately left untouched.
      state        <= IDLE;
      win_clr      <= 1'b0;
      meas_en      <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      div_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            win_clr  <= 1'b1;
            err_div0 <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          win_clr    <= 1'b0;
          gate_len_q <= (gate_len == '0) ? GL_W'(1) : gate_len;
          gate_cnt   <= '0;
          meas_en    <= 1'b1;
          state      <= GATE;
        end
        GATE: begin
          if (sample_valid) begin
            gate_cnt <= gate_cnt + GL_W'(1);
            if ((gate_cnt + GL_W'(1)) == gate_len_q) begin
              meas_en    <= 1'b0;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt == ST_W'(SETTLE_LAST)) begin
            zc_s     <= zc_cnt[OUT_W-1:0];
            high_s   <= high_cnt;
            total_s  <= total_cnt;
`ifdef PSEQ_THD_EN
            fund_s   <= fund_pow;
            harm_s   <= harm_pow;
`endif
            div_busy <= 1'b0;
            state    <= DIV_DUTY;
          end else begin
            settle_cnt <= settle_cnt + ST_W'(1);
          end
        end
        DIV_DUTY, DIV_THD: begin
          if (div_fin) begin
            div_busy <= 1'b0;
            if (div_zero) err_div0 <= 1'b1;
`ifdef PSEQ_THD_EN
            if (state == DIV_DUTY) begin
              duty_q <= div_res;
              state  <= DIV_THD;
            end else begin
              freq_out     <= zc_s;
              duty_out     <= duty_q;
              thd_out      <= div_res;
              result_valid <= 1'b1;
              state        <= PUBLISH;
            end
`else
            freq_out     <= zc_s;
            duty_out     <= div_res;
            thd_out      <= '0;
            result_valid <= 1'b1;
            state        <= PUBLISH;
`endif
          end else if (!div_busy) begin
            dvd      <= NUM_W'(num_sel) * NUM_W'(SCALE);
            dsr      <= dsr_sel;
            rem      <= '0;
            it_cnt   <= IT_W'(NUM_W);
            div_busy <= 1'b1;
          end else begin
            dvd    <= dvd_next;
            rem    <= rem_next;
            it_cnt <= it_cnt - IT_W'(1);
          end
        end
        PUBLISH: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (continuous) begin
              state    <= CLEAR;
              win_clr  <= 1'b1;
              err_div0 <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_measure_sequencer.sv
// Directed bench for param_measure_sequencer; THD expectations follow PSEQ_THD_EN.
module tb_param_measure_sequencer;

`ifdef PSEQ_THD_EN
  localparam bit THD_ON = 1'b1;
`else
  localparam bit THD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, continuous, abort, sample_valid, result_ready;
  logic [19:0] gate_len;
  logic [31:0] zc_cnt, high_cnt, total_cnt, fund_pow, harm_pow;
  logic        win_clr, meas_en, result_valid, busy, err_div0;
  logic [15:0] freq_out, duty_out, thd_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  param_measure_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .abort(abort),
    .gate_len(gate_len), .sample_valid(sample_valid),
    .zc_cnt(zc_cnt), .high_cnt(high_cnt), .total_cnt(total_cnt),
    .fund_pow(fund_pow), .harm_pow(harm_pow),
    .win_clr(win_clr), .meas_en(meas_en),
    .freq_out(freq_out), .duty_out(duty_out), .thd_out(thd_out),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .err_div0(err_div0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic handshake(input bit cont);
    continuous   = cont;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  // Ticks until result_valid, counting cycles with meas_en high.
  task automatic wait_result(input int budget, output int en_cyc, output bit got);
    en_cyc = 0;
    got    = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (meas_en) en_cyc++;
      if (result_valid) got = 1'b1;
    end
  endtask

  int          en;
  bit          got;
  int          stable;
  int          seen;
  logic [15:0] thd_exp;

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    sample_valid = 1'b0; result_ready = 1'b0; gate_len = '0;
    zc_cnt = '0; high_cnt = '0; total_cnt = '0; fund_pow = '0; harm_pow = '0;
    thd_exp = THD_ON ? 16'd250 : 16'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_meas_en", meas_en, 0);
    check("rst_win_clr", win_clr, 0);
    check("rst_outputs", {freq_out, duty_out} | 32'(thd_out), 0);
    check("rst_err", err_div0, 0);

    // Run 1: nominal duty 25.0%, THD 25.0%
    gate_len = 20'd1000; zc_cnt = 50; high_cnt = 250; total_cnt = 1000;
    fund_pow = 400; harm_pow = 100; sample_valid = 1'b1; continuous = 1'b1;
    pulse_start();
    check("start_win_clr", win_clr, 1);
    check("start_busy", busy, 1);
    check("clear_meas_en", meas_en, 0);
    wait_result(3000, en, got);
    check("run1_done", got, 1);
    check("run1_gate_cycles", en, 1000);
    check("run1_duty", duty_out, 250);
    check("run1_freq", freq_out, 50);
    check("run1_thd", thd_out, thd_exp);
    check("run1_err", err_div0, 0);

    // Hold ready low: outputs must not move
    stable = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (result_valid && duty_out == 16'd250 && freq_out == 16'd50 &&
          thd_out == thd_exp && !win_clr) stable++;
    end
    check("hold_stable", stable, 100);

    handshake(1'b1);
    check("cont_win_clr", win_clr, 1);
    check("cont_valid_drop", result_valid, 0);
    check("cont_busy", busy, 1);
    fund_pow = 0;

    // Run 2: zero fundamental
    wait_result(3000, en, got);
    check("run2_done", got, 1);
    check("run2_gate_cycles", en, 1000);
    check("run2_duty", duty_out, 250);
    check("run2_thd", thd_out, 0);
    check("run2_err", err_div0, 32'(THD_ON));
    repeat (5) tick();
    check("run2_err_hold", err_div0, 32'(THD_ON));
    handshake(1'b0);
    check("idle_busy", busy, 0);
    check("idle_valid", result_valid, 0);
    check("idle_win_clr", win_clr, 0);
    check("idle_err_sticky", err_div0, 32'(THD_ON));
    check("idle_duty_kept", duty_out, 250);

    // Run 3: gate_len 0 acts as 1, zero total count
    gate_len = 20'd0; total_cnt = 0; fund_pow = 400;
    pulse_start();
    check("run3_err_cleared", err_div0, 0);
    wait_result(500, en, got);
    check("run3_done", got, 1);
    check("run3_gate_cycles", en, 1);
    check("run3_duty", duty_out, 0);
    check("run3_err", err_div0, 1);
    handshake(1'b0);

    // Run 4: saturating duty, start during measurement ignored
    gate_len = 20'd8; high_cnt = 100; total_cnt = 1; continuous = 1'b1;
    pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    en = 0;
    wait_result(500, en, got);
    check("run4_done", got, 1);
    check("run4_gate_cycles", en + 1, 8);
    check("run4_duty_sat", duty_out, 16'hFFFF);
    check("run4_thd", thd_out, thd_exp);
    check("run4_err", err_div0, 0);

    // Abort beats handshake even with continuous set
    abort = 1'b1; result_ready = 1'b1;
    tick();
    abort = 1'b0; result_ready = 1'b0;
    check("abort_pub_valid", result_valid, 0);
    check("abort_pub_busy", busy, 0);
    check("abort_pub_win_clr", win_clr, 0);
    check("abort_pub_duty", duty_out, 16'hFFFF);
    tick();
    check("abort_pub_stays_idle", {31'd0, busy | win_clr}, 0);

    // Run 5: abort mid-gate
    gate_len = 20'd1000; high_cnt = 250; total_cnt = 1000; continuous = 1'b0;
    pulse_start();
    seen = 0;
    for (int i = 0; i < 2000 && seen < 500; i++) begin
      tick();
      if (meas_en) seen++;
    end
    check("run5_reach_500", seen, 500);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_meas_en", meas_en, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", result_valid, 0);
    check("abort_duty_kept", duty_out, 16'hFFFF);
    check("abort_freq_kept", freq_out, 50);
    repeat (60) tick();
    check("abort_stays_idle", {30'd0, busy, result_valid}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
